// File: rtl/pipe_add_pkg.sv
// Shared definitions for the pipelined adder-subtractor: mode encodings and
// the per-stage carry-chunk width helper.
package pipe_add_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  localparam logic MODE_UNS = 1'b0;
  localparam logic MODE_SGN = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// N-bit carry-lookahead adder: each carry is a flat sum of products of the
// generate/propagate terms, so no carry ripples inside a chunk.
module cla_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         acc;
  logic         term;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    acc  = 1'b0;
    term = 1'b0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      // c[i+1] = p[i:0]&cin | OR_j (g[j] & p[i:j+1])
      acc = cin;
      for (int m = 0; m <= i; m++) acc = acc & p[m];
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/pipe_add_tc.sv
// Pipelined signed/unsigned adder-subtractor: one input register, then one
// register stage per carry chunk; operands rotate right so the next chunk is always at bit 0.
module pipe_add_tc
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  // Handshake: a beat moves on an edge where valid && ready. The whole pipe
  // advances only when the output slot is empty or being drained (en), so
  // in_ready is that same enable and backpressure freezes every stage.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // r_*[k] is the state entering stage k; r_*[0] is the captured, extended beat.
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic             r_c   [STAGES];
  logic             r_ax  [STAGES];
  logic             r_bx  [STAGES];
  logic             r_sgn [STAGES];
  logic             r_v   [STAGES];

  logic [CHUNK-1:0] cs [STAGES];
  logic             co [STAGES];

  logic top_bit;
  logic ovf_next;

  function automatic logic [WIDTH-1:0] rotate_in(input logic [WIDTH-1:0] x,
                                                 input logic [CHUNK-1:0] s);
    return (x >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_chunk #(.N(CHUNK)) u_cla (
      .a    (r_a[k][CHUNK-1:0]),
      .b    (r_b[k][CHUNK-1:0]),
      .cin  (r_c[k]),
      .sum  (cs[k]),
      .cout (co[k])
    );
  end

  // Extension bit is folded into the last stage together with its chunk carry.
  always_comb begin
    top_bit  = r_ax[LAST] ^ r_bx[LAST] ^ co[LAST];
    ovf_next = (r_sgn[LAST] == MODE_SGN) ? (top_bit ^ cs[LAST][CHUNK-1]) : top_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_c[k]   <= 1'b0;
        r_ax[k]  <= 1'b0;
        r_bx[k]  <= 1'b0;
        r_sgn[k] <= 1'b0;
        r_v[k]   <= 1'b0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      r_a[0]   <= a;
      r_b[0]   <= (sub == MODE_SUB) ? ~b : b;
      r_c[0]   <= (sub == MODE_ADD) ? cin : 1'b1;
      r_ax[0]  <= (sgn == MODE_UNS) ? 1'b0 : a[WIDTH-1];
      r_bx[0]  <= ((sgn == MODE_UNS) ? 1'b0 : b[WIDTH-1]) ^ (sub == MODE_SUB);
      r_sgn[0] <= sgn;
      r_v[0]   <= in_valid;
      for (int k = 0; k < STAGES - 1; k++) begin
        r_a[k+1]   <= rotate_in(r_a[k], cs[k]);
        r_b[k+1]   <= r_b[k] >> CHUNK;
        r_c[k+1]   <= co[k];
        r_ax[k+1]  <= r_ax[k];
        r_bx[k+1]  <= r_bx[k];
        r_sgn[k+1] <= r_sgn[k];
        r_v[k+1]   <= r_v[k];
      end
      out_valid <= r_v[LAST];
      if (r_v[LAST]) begin
        sum <= {top_bit, rotate_in(r_a[LAST], cs[LAST])};
        ovf <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_pipe_add_tc.sv
// Self-checking bench for pipe_add_tc (WIDTH=16, STAGES=4): directed corner
// cases, latency, throughput, backpressure, async reset and a random run.
module tb_pipe_add_tc;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         sgn;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_acc  = 0;
  int n_out  = 0;

  logic [W+1:0] exp_q[$];

  pipe_add_tc #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub, input logic msgn);
    longint va, vb, r, smax, smin, umax;
    logic ov;
    logic [W:0] s;
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    umax = (longint'(1) <<< W) - 1;
    va = msgn ? longint'($signed(ma)) : longint'(ma);
    vb = msgn ? longint'($signed(mb)) : longint'(mb);
    r  = msub ? (va - vb) : (va + vb + longint'(mcin));
    if (msgn) ov = (r > smax) || (r < smin);
    else if (msub) ov = (r < 0);
    else ov = (r > umax);
    s = r[W:0];
    return {ov, s};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got sum=%h ovf=%b with empty queue", sum, ovf);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          if ({ovf, sum} !== e) begin
            errors++;
            $display("FAIL sb_result: got ovf=%b sum=%h, expected ovf=%b sum=%h",
                     ovf, sum, e[W+1], e[W:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        exp_q.push_back(model(a, b, cin, sub, sgn));
      end
    end
  end

  // ---------------- drivers ----------------
  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 16'h0001;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      4:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive_beat(input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vcin, input logic vsub, input logic vsgn);
    a        = va;
    b        = vb;
    cin      = vcin;
    sub      = vsub;
    sgn      = vsgn;
    in_valid = 1'b1;
  endtask

  task automatic drive_rand();
    drive_beat(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    @(posedge clk); #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    checks++;
    if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h need 0", sum); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b need 0", ovf); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b need 0", out_valid); end
  endtask

  logic [W-1:0] dv_a   [7] = '{16'h7FFF, 16'hFFFF, 16'h1234, 16'h8000, 16'h0001, 16'h0005, 16'hFFFF};
  logic [W-1:0] dv_b   [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'hFFFE};
  logic         dv_cin [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic         dv_sub [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic         dv_sgn [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [W:0]   dv_sum [7] = '{17'h08000, 17'h10000, 17'h01236, 17'h17FFF, 17'h1FFFF, 17'h00002, 17'h1FFFD};
  logic         dv_ovf [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic test_directed();
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #2;
      drive_beat(dv_a[i], dv_b[i], dv_cin[i], dv_sub[i], dv_sgn[i]);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready: got %b need 1", i, in_ready); end
      @(posedge clk); #2;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #2;
        lat++;
      end
      checks++;
      if (lat != S) begin errors++; $display("FAIL dir%0d_latency: got %0d need %0d", i, lat, S); end
      checks++;
      if (sum !== dv_sum[i]) begin errors++; $display("FAIL dir%0d_sum: got %h need %h", i, sum, dv_sum[i]); end
      checks++;
      if (ovf !== dv_ovf[i]) begin errors++; $display("FAIL dir%0d_ovf: got %b need %b", i, ovf, dv_ovf[i]); end
    end
    @(posedge clk); #2;
  endtask

  task automatic test_back_to_back();
    int seen, first_cyc, last_cyc, acc0;
    bit ok;
    seen = 0; first_cyc = 0; last_cyc = 0;
    acc0 = n_acc;
    out_ready = 1'b1;
    @(posedge clk); #2;
    drive_rand();
    for (int i = 1; i < 40 && seen < 10; i++) begin
      @(posedge clk); #2;
      if (i == 1) first_cyc = cyc;
      if (out_valid) begin
        seen++;
        if (seen == 10) last_cyc = cyc;
      end
      if (i < 10) drive_rand();
      else in_valid = 1'b0;
    end
    checks++;
    if (seen != 10) begin errors++; $display("FAIL b2b_outputs: got %0d need 10", seen); end
    checks++;
    if (last_cyc - first_cyc + 1 != 14) begin
      errors++; $display("FAIL b2b_cycles: got %0d need 14", last_cyc - first_cyc + 1);
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_drain: queue=%0d need 0", exp_q.size()); end
    checks++;
    if (n_acc - acc0 != 10) begin errors++; $display("FAIL b2b_accepts: got %0d need 10", n_acc - acc0); end
  endtask

  task automatic test_backpressure();
    int acc, out0;
    logic [W:0] held_sum;
    logic held_ovf;
    logic exp_ready;
    bit ok;
    acc = 0;
    out0 = n_out;
    held_sum = '0;
    held_ovf = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        @(posedge clk); #2;
      end
      out_ready = !(i >= 6 && i <= 9);
      if (acc < 10) drive_rand();
      else in_valid = 1'b0;
      #1;
      exp_ready = !(i >= 6 && i <= 9);
      checks++;
      if (in_ready !== exp_ready) begin
        errors++; $display("FAIL bp_in_ready_c%0d: got %b need %b", i, in_ready, exp_ready);
      end
      if (i == 6) begin
        held_sum = sum;
        held_ovf = ovf;
      end else if (i > 6 && i <= 9) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== held_sum || ovf !== held_ovf) begin
          errors++;
          $display("FAIL bp_hold_c%0d: got v=%b sum=%h ovf=%b need v=1 sum=%h ovf=%b",
                   i, out_valid, sum, ovf, held_sum, held_ovf);
        end
      end
      if (in_valid && in_ready) acc++;
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_drain: queue=%0d need 0", exp_q.size()); end
    checks++;
    if (n_out - out0 != 10) begin errors++; $display("FAIL bp_outputs: got %0d need 10", n_out - out0); end
  endtask

  task automatic test_reset_midflight();
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      drive_rand();
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b need 1", out_valid); end
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b need 0", out_valid); end
    checks++;
    if (sum !== '0) begin errors++; $display("FAIL mid_rst_sum: got %h need 0", sum); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf: got %b need 0", ovf); end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b need 1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #2;
    drive_beat(16'h00FF, 16'h0101, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #2;
      lat++;
    end
    checks++;
    if (lat != S) begin errors++; $display("FAIL mid_latency: got %0d need %0d", lat, S); end
    checks++;
    if (sum !== 17'h00200 || ovf !== 1'b0) begin
      errors++; $display("FAIL mid_result: got sum=%h ovf=%b need sum=00200 ovf=0", sum, ovf);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_random();
    int acc;
    bit ok;
    acc = 0;
    for (int i = 0; i < 20000 && acc < 1000; i++) begin
      @(posedge clk); #2;
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 7) drive_rand();
      else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) acc++;
    end
    checks++;
    if (acc != 1000) begin errors++; $display("FAIL rand_accepts: got %0d need 1000", acc); end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rand_drain: queue=%0d need 0", exp_q.size()); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    sgn       = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_add_tc.md
Name: pipe_add_tc

Overview:
- Parametrised, pipelined two's-complement / unsigned adder-subtractor; the successor to the fixed 16+16 fast adder.
- Generalised in operand width and pipeline depth; adds runtime signed/unsigned and add/sub modes, carry-in and an overflow flag.
- Carry chain split into STAGES equal chunks, one per register stage, with a valid/ready handshake and backpressure.
- Used as the arithmetic core in datapaths that need a throughput of one operation per clock at high frequency.

Parameters:
- WIDTH, 16, operand width in bits; must be divisible by STAGES.
- STAGES, 4, pipeline stages (carry chunks), 1..WIDTH; latency equals STAGES.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in, added as +1 LSB; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A-B.
- sgn  input  1  1: operands signed two's complement; 0: unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH+1  exact result as a (WIDTH+1)-bit two's-complement value in signed mode and unsigned sub; as an unsigned value in unsigned add.
- ovf  output  1  result not representable in WIDTH bits of the selected mode.

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits, out_valid, sum and ovf are cleared to 0.
  - in_ready is combinational and therefore reads 1 during and after reset.
  - A reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Global enable: en = !out_valid || out_ready; in_ready = en.
  - A beat is accepted when in_valid && in_ready.
  - Every stage register, including valid bits, updates only when en=1.
  - Bubbles propagate as valid=0.
- Extension:
  - Operands are extended to WIDTH+1 bits: sign-extended if sgn=1, zero-extended if sgn=0.
  - For sub=1: B_ext is inverted and the chunk-0 carry-in is forced to 1.
  - For sub=0: the chunk-0 carry-in is cin.
- Pipeline:
  - Stage k (0..STAGES-1) computes chunk k of width WIDTH/STAGES from the carry registered by stage k-1.
  - Chunk k uses a carry-lookahead adder internally.
  - Unconsumed upper operand chunks and already computed lower sum chunks are delayed alongside.
  - The extension bit WIDTH is summed in the last stage.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES, provided en stays 1. Throughput is 1 beat per cycle.
- Stall:
  - While out_valid=1 and out_ready=0, sum, ovf and out_valid hold stable.
  - All internal stages freeze and in_ready=0; no beat is lost or duplicated.
- Simultaneous events: when out_ready=1 and in_valid=1 with a full pipeline, the output retires and a new beat enters on the same edge.
- Overflow, computed in the final stage:
  - Signed (add or sub): ovf = sum[WIDTH] ^ sum[WIDTH-1].
  - Unsigned add: ovf = sum[WIDTH] (carry out).
  - Unsigned sub: ovf = sum[WIDTH] (borrow; sum is negative).
- Mode bits sub and sgn travel with their beat, so mixed-mode back-to-back beats are legal.
- STAGES=1 degenerates to a single registered adder with latency 1.

Decomposition:
- Shared package pipe_add_pkg:
  - localparam helper for CHUNK = WIDTH/STAGES.
  - Mode encoding constants: MODE_ADD=0, MODE_SUB=1, MODE_UNS=0, MODE_SGN=1.
- One sub-module cla_chunk, instantiated once per stage via a generate loop:
  - Parametrised CHUNK-bit carry-lookahead adder with a cin/cout interface.

Test Plan (WIDTH=16, STAGES=4):
- Signed add: a=0x7FFF, b=0x0001, sgn=1, sub=0 → sum=0x08000, ovf=1, exactly 4 cycles after accept.
- Unsigned add with carry: a=0xFFFF, b=0x0001, sgn=0, cin=0 → sum=0x10000, ovf=1. Repeat with a=0x1234, b=0x0001, cin=1 → sum=0x01236, ovf=0.
- Subtraction:
  - Signed: a=0x8000, b=0x0001, sgn=1, sub=1 → sum=0x17FFF (−32769), ovf=1.
  - Unsigned: a=0x0001, b=0x0002 → sum=0x1FFFF, ovf=1.
- Throughput and backpressure:
  - Feed 10 back-to-back random beats with out_ready held low for cycles 6..9.
  - Required: no loss or duplication, outputs in order and matching a reference model, in_ready=0 exactly during the stall.
  - With no stall, 10 beats complete in 14 cycles.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight → out_valid=0, sum=0, ovf=0 immediately (asynchronously). After release, the first new beat's result appears 4 cycles after its accept, with no stale output.
- Random regression over 1000 beats with random in_valid/out_ready, sgn, sub and cin, checked against the reference model.
